// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner/debouncer.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Linear key number: row-major across the matrix.
    function automatic int unsigned kp_code(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
        return row * cols + col;
    endfunction

    // Counter width able to hold max_val; never below one bit.
    function automatic int unsigned kp_cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_n.sv
// WIDTH-bit two-flop synchroniser with a configurable reset level.
module sync_n #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage absorbs metastability, second stage presents a clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner with press/release debounce and optional auto-repeat.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 48000,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CODE_W          = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_keys,
    output logic [COLS-1:0]   col_keys,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned SET_W = kp_cnt_w(SETTLE_CYCLES);
    localparam int unsigned DEB_W = kp_cnt_w(DEBOUNCE_CYCLES);
    localparam int unsigned REP_W = kp_cnt_w(REPEAT_CYCLES);

    localparam logic [ROWS-1:0]  ROW_IDLE    = {ROWS{ACTIVE_LOW}};
    localparam logic [COLS-1:0]  COL0_ONEHOT = COLS'(1);
    localparam logic [COLS-1:0]  COL_RST     = ACTIVE_LOW ? ~COL0_ONEHOT : COL0_ONEHOT;
    localparam logic [SET_W-1:0] SET_LAST    = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST    = REP_W'(REPEAT_CYCLES - 1);

    kp_state_t         state, state_nxt;
    logic [COL_W-1:0]  col_idx, col_nxt, col_adv;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic [DEB_W-1:0]  deb_cnt, deb_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_nxt;
    logic [ROW_W-1:0]  cap_row, cap_row_nxt, low_row;
    logic [CODE_W-1:0] cap_code, cap_code_nxt, code_nxt;
    logic [COLS-1:0]   col_onehot, col_keys_nxt;
    logic              valid_nxt, held_nxt;
    logic [ROWS-1:0]   row_sync, row_act;
    logic              any_row, cap_hit;

    sync_n #(
        .WIDTH   (ROWS),
        .RST_VAL (ROW_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (row_keys),
        .q     (row_sync)
    );

    // Normalise row polarity and locate the lowest asserted row.
    always_comb begin
        row_act = row_sync ^ ROW_IDLE;
        any_row = |row_act;
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_act[r]) low_row = ROW_W'(r);
        end
        cap_hit = row_act[cap_row];
        col_adv = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
    end

    // Next-state and next-output logic for scan, debounce, hold and release.
    always_comb begin
        state_nxt    = state;
        col_nxt      = col_idx;
        settle_nxt   = settle_cnt;
        deb_nxt      = deb_cnt;
        rep_nxt      = rep_cnt;
        cap_row_nxt  = cap_row;
        cap_code_nxt = cap_code;
        code_nxt     = key_code;
        valid_nxt    = 1'b0;
        held_nxt     = key_held;

        case (state)
            SCAN: begin
                if (settle_cnt == SET_LAST) begin
                    settle_nxt = '0;
                    if (any_row) begin
                        cap_row_nxt  = low_row;
                        cap_code_nxt = CODE_W'(kp_code(32'(low_row), 32'(col_idx), COLS));
                        deb_nxt      = '0;
                        state_nxt    = DEBOUNCE;
                    end else begin
                        col_nxt = col_adv;
                    end
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
            end
            DEBOUNCE: begin
                if (cap_hit) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_nxt = HELD;
                        code_nxt  = cap_code;
                        valid_nxt = 1'b1;
                        held_nxt  = 1'b1;
                        deb_nxt   = '0;
                        rep_nxt   = '0;
                    end else begin
                        deb_nxt = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    deb_nxt    = '0;
                    settle_nxt = '0;
                    col_nxt    = col_adv;
                    state_nxt  = SCAN;
                end
            end
            HELD: begin
                if (!cap_hit) begin
                    state_nxt = RELEASE;
                    rep_nxt   = '0;
                    deb_nxt   = '0;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_cnt == REP_LAST) begin
                        valid_nxt = 1'b1;
                        rep_nxt   = '0;
                    end else begin
                        rep_nxt = rep_cnt + REP_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (cap_hit) begin
                    state_nxt = HELD;
                    rep_nxt   = '0;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt  = SCAN;
                    held_nxt   = 1'b0;
                    deb_nxt    = '0;
                    settle_nxt = '0;
                    col_nxt    = col_adv;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase

        col_onehot   = COL0_ONEHOT << col_nxt;
        col_keys_nxt = ACTIVE_LOW ? ~col_onehot : col_onehot;
    end

    // State register and all registered outputs/counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SCAN;
            col_idx    <= '0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            rep_cnt    <= '0;
            cap_row    <= '0;
            cap_code   <= '0;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            col_keys   <= COL_RST;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_nxt;
            settle_cnt <= settle_nxt;
            deb_cnt    <= deb_nxt;
            rep_cnt    <= rep_nxt;
            cap_row    <= cap_row_nxt;
            cap_code   <= cap_code_nxt;
            key_code   <= code_nxt;
            key_valid  <= valid_nxt;
            key_held   <= held_nxt;
            col_keys   <= col_keys_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: one instance without repeat, one with.
module tb_keypad_scan_debounce;

    typedef struct {
        int row;
        int col;
        int code;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] keys0, keys1;
    logic [3:0]  rows0, rows1, cols0, cols1, code0, code1;
    logic        valid0, valid1, held0, held1;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt0   = 0;
    int vcnt1   = 0;

    always #5 clk = ~clk;

    keypad_scan_debounce #(
        .ROWS(4), .COLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .row_keys(rows0), .col_keys(cols0),
        .key_code(code0), .key_valid(valid0), .key_held(held0)
    );

    keypad_scan_debounce #(
        .ROWS(4), .COLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES(20), .ACTIVE_LOW(1'b1)
    ) dut_r (
        .clk(clk), .reset(reset), .row_keys(rows1), .col_keys(cols1),
        .key_code(code1), .key_valid(valid1), .key_held(held1)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows0 = 4'hF;
        rows1 = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys0[r*4+c] && !cols0[c]) rows0[r] = 1'b0;
                if (keys1[r*4+c] && !cols1[c]) rows1[r] = 1'b0;
            end
        end
    end

    // Strobe counters.
    always @(negedge clk) begin
        if (valid0) vcnt0++;
        if (valid1) vcnt1++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int which, input int r, input int c, input logic v);
        if (which == 0) keys0[r*4+c] = v;
        else            keys1[r*4+c] = v;
    endtask

    task automatic wait_held(input int which, input logic lvl, input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (((which == 0) ? held0 : held1) == lvl) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if ((which == 0) ? valid0 : valid1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (cols0 == target) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        vec_t       vecs [6];
        logic [3:0] rot_exp [3];
        logic [3:0] prev;
        int         cyc, base, k, held_min, nrep;
        int         rt [3];

        vecs[0] = '{row: 2, col: 1, code: 9};
        vecs[1] = '{row: 0, col: 0, code: 0};
        vecs[2] = '{row: 3, col: 3, code: 15};
        vecs[3] = '{row: 1, col: 2, code: 6};
        vecs[4] = '{row: 3, col: 0, code: 12};
        vecs[5] = '{row: 0, col: 2, code: 2};
        rot_exp[0] = 4'b1101;
        rot_exp[1] = 4'b1011;
        rot_exp[2] = 4'b0111;

        reset = 1'b0;
        keys0 = '0;
        keys1 = '0;
        repeat (3) @(negedge clk);
        check("rst_col", int'(cols0), 4'b1110);
        check("rst_code", int'(code0), 0);
        check("rst_valid", int'(valid0), 0);
        check("rst_held", int'(held0), 0);
        check("rst_col_r", int'(cols1), 4'b1110);
        reset = 1'b1;

        // Table: press, hold 100 cycles, release.
        for (int i = 0; i < 6; i++) begin
            base = vcnt0;
            press(0, vecs[i].row, vecs[i].col, 1'b1);
            wait_held(0, 1'b1, 80, cyc);
            check("vec_held_rise", int'(cyc > 0), 1);
            repeat (100) @(negedge clk);
            check("vec_strobes", vcnt0 - base, 1);
            check("vec_code", int'(code0), vecs[i].code);
            check("vec_held", int'(held0), 1);
            press(0, vecs[i].row, vecs[i].col, 1'b0);
            repeat (20) @(negedge clk);
            check("vec_released", int'(held0), 0);
        end

        // Scanning rotates through all columns when idle.
        wait_col(4'b1110, 40, cyc);
        check("rot_find", int'(cyc > 0), 1);
        prev = cols0;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (cols0 == prev && k < 8) begin
                @(negedge clk);
                k++;
            end
            check("rot_step", int'(cols0), int'(rot_exp[i]));
            prev = cols0;
        end

        // Exact latency from the start of a column window.
        wait_col(4'b1011, 40, cyc);
        press(0, 3, 2, 1'b1);
        wait_valid(0, 40, cyc);
        check("latency", cyc, 12);
        check("latency_code", int'(code0), 14);
        press(0, 3, 2, 1'b0);
        wait_held(0, 1'b0, 40, cyc);
        check("latency_release", int'(cyc > 0), 1);

        // Bounce: short press is rejected, then a stable press is accepted once.
        base = vcnt0;
        wait_col(4'b0111, 40, cyc);
        press(0, 0, 3, 1'b1);
        repeat (5) @(negedge clk);
        press(0, 0, 3, 1'b0);
        repeat (3) @(negedge clk);
        check("bounce_quiet", vcnt0 - base, 0);
        press(0, 0, 3, 1'b1);
        repeat (8) @(negedge clk);
        check("bounce_early", vcnt0 - base, 0);
        wait_held(0, 1'b1, 60, cyc);
        check("bounce_accept", int'(cyc > 0), 1);
        repeat (5) @(negedge clk);
        check("bounce_strobes", vcnt0 - base, 1);
        check("bounce_code", int'(code0), 3);
        press(0, 0, 3, 1'b0);
        wait_held(0, 1'b0, 40, cyc);
        check("bounce_release", int'(cyc > 0), 1);

        // Auto-repeat every 20 cycles on the repeat instance.
        press(1, 3, 3, 1'b1);
        wait_valid(1, 60, cyc);
        check("rep_accept", int'(cyc > 0), 1);
        check("rep_accept_code", int'(code1), 15);
        rt = '{-1, -1, -1};
        nrep = 0;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (valid1) begin
                if (nrep < 3) rt[nrep] = j;
                nrep++;
                check("rep_code", int'(code1), 15);
            end
        end
        check("rep_count", nrep, 3);
        check("rep_t0", rt[0], 20);
        check("rep_t1", rt[1], 40);
        check("rep_t2", rt[2], 60);
        press(1, 3, 3, 1'b0);
        wait_held(1, 1'b0, 40, cyc);
        check("rep_release", int'(cyc > 0), 1);

        // Other keys ignored while held; a key left down is found after release.
        base = vcnt0;
        press(0, 1, 0, 1'b1);
        wait_held(0, 1'b1, 80, cyc);
        check("multi_accept", int'(cyc > 0), 1);
        press(0, 2, 0, 1'b1);
        press(0, 1, 2, 1'b1);
        repeat (40) @(negedge clk);
        check("multi_strobes", vcnt0 - base, 1);
        check("multi_code", int'(code0), 4);
        press(0, 1, 2, 1'b0);
        press(0, 1, 0, 1'b0);
        wait_held(0, 1'b0, 40, cyc);
        check("multi_release", int'(cyc > 0), 1);
        wait_held(0, 1'b1, 80, cyc);
        check("multi_next", int'(cyc > 0), 1);
        repeat (3) @(negedge clk);
        check("multi_next_code", int'(code0), 8);
        check("multi_next_strobes", vcnt0 - base, 2);
        press(0, 2, 0, 1'b0);
        wait_held(0, 1'b0, 40, cyc);
        check("multi_next_release", int'(cyc > 0), 1);

        // Release glitch shorter than debounce keeps the key held.
        base = vcnt0;
        press(0, 1, 1, 1'b1);
        wait_held(0, 1'b1, 80, cyc);
        check("glitch_accept", int'(cyc > 0), 1);
        held_min = 1;
        press(0, 1, 1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            if (!held0) held_min = 0;
        end
        press(0, 1, 1, 1'b1);
        repeat (20) begin
            @(negedge clk);
            if (!held0) held_min = 0;
        end
        check("glitch_held", held_min, 1);
        check("glitch_strobes", vcnt0 - base, 1);
        check("glitch_code", int'(code0), 5);
        press(0, 1, 1, 1'b0);
        wait_held(0, 1'b0, 40, cyc);
        check("glitch_release", int'(cyc > 0), 1);

        // Reset during DEBOUNCE.
        wait_col(4'b1101, 40, cyc);
        press(0, 2, 1, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstdeb_col", int'(cols0), 4'b1110);
        check("rstdeb_code", int'(code0), 0);
        check("rstdeb_held", int'(held0), 0);
        check("rstdeb_valid", int'(valid0), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_valid(0, 40, cyc);
        check("rstdeb_relatch", cyc, 16);
        check("rstdeb_relatch_code", int'(code0), 9);

        // Reset during HELD.
        repeat (5) @(negedge clk);
        check("rsthld_pre", int'(held0), 1);
        reset = 1'b0;
        #1;
        check("rsthld_col", int'(cols0), 4'b1110);
        check("rsthld_code", int'(code0), 0);
        check("rsthld_held", int'(held0), 0);
        check("rsthld_valid", int'(valid0), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_valid(0, 40, cyc);
        check("rsthld_relatch", cyc, 16);
        press(0, 2, 1, 1'b0);
        wait_held(0, 1'b0, 40, cyc);
        check("rsthld_release", int'(cyc > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
